// File: rtl/rx_cmd_ctrl.sv
// Debug-unit command sequencer: decodes bytes from the UART receiver, assembles LOAD
// payloads into little-endian words for program memory, and drives CPU run/step control.
module rx_cmd_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_rx_done,
    input  logic [DATA_BITS-1:0]              i_rx_data,
    output logic                              o_mem_we,
    output logic [ADDR_W-1:0]                 o_mem_addr,
    output logic [WORD_BYTES*DATA_BITS-1:0]   o_mem_data,
    output logic                              o_run,
    output logic                              o_step,
    output logic                              o_load_done,
    output logic                              o_err
);

    localparam int W       = WORD_BYTES * DATA_BITS;
    localparam int BCNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [BCNT_W-1:0]    BYTE_LAST  = BCNT_W'(WORD_BYTES - 1);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [DATA_BITS-1:0] CMD_LOAD   = DATA_BITS'(8'h4C);
    localparam logic [DATA_BITS-1:0] CMD_RUN    = DATA_BITS'(8'h52);
    localparam logic [DATA_BITS-1:0] CMD_HALT   = DATA_BITS'(8'h48);
    localparam logic [DATA_BITS-1:0] CMD_STEP   = DATA_BITS'(8'h53);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t               state_reg,      state_next;
    logic                 run_reg,        run_next;
    logic                 step_reg,       step_next;
    logic                 err_reg,        err_next;
    logic                 done_reg,       done_next;
    logic                 we_reg,         we_next;
    logic [ADDR_W-1:0]    mem_addr_reg,   mem_addr_next;
    logic [W-1:0]         word_reg,       word_next;
    logic [BCNT_W-1:0]    byte_cnt_reg,   byte_cnt_next;
    logic [DATA_BITS-1:0] words_left_reg, words_left_next;
    logic [ADDR_W-1:0]    addr_cnt_reg,   addr_cnt_next;
    logic [TIMER_W-1:0]   timer_reg,      timer_next;

    logic [W-1:0]         word_shift;
    logic                 timeout_hit;

    // New byte enters the top lane so the first byte of a word ends up in the low lane.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            if (gi == WORD_BYTES - 1) begin : g_top
                assign word_shift[gi*DATA_BITS +: DATA_BITS] = i_rx_data;
            end else begin : g_low
                assign word_shift[gi*DATA_BITS +: DATA_BITS] = word_reg[(gi+1)*DATA_BITS +: DATA_BITS];
            end
        end
    endgenerate

    assign timeout_hit = (timer_reg == TIMER_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg      <= ST_IDLE;
            run_reg        <= 1'b0;
            step_reg       <= 1'b0;
            err_reg        <= 1'b0;
            done_reg       <= 1'b0;
            we_reg         <= 1'b0;
            mem_addr_reg   <= '0;
            word_reg       <= '0;
            byte_cnt_reg   <= '0;
            words_left_reg <= '0;
            addr_cnt_reg   <= '0;
            timer_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            run_reg        <= run_next;
            step_reg       <= step_next;
            err_reg        <= err_next;
            done_reg       <= done_next;
            we_reg         <= we_next;
            mem_addr_reg   <= mem_addr_next;
            word_reg       <= word_next;
            byte_cnt_reg   <= byte_cnt_next;
            words_left_reg <= words_left_next;
            addr_cnt_reg   <= addr_cnt_next;
            timer_reg      <= timer_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        run_next        = run_reg;
        step_next       = 1'b0;
        err_next        = 1'b0;
        done_next       = 1'b0;
        we_next         = 1'b0;
        mem_addr_next   = mem_addr_reg;
        word_next       = word_reg;
        byte_cnt_next   = byte_cnt_reg;
        words_left_next = words_left_reg;
        addr_cnt_next   = addr_cnt_reg;
        timer_next      = timer_reg;

        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                if (i_rx_done) begin
                    if (i_rx_data == CMD_LOAD) begin
                        // Loading while the CPU runs could overwrite live code.
                        if (run_reg) begin
                            err_next = 1'b1;
                        end else begin
                            state_next    = ST_LEN;
                            addr_cnt_next = '0;
                            byte_cnt_next = '0;
                        end
                    end else if (i_rx_data == CMD_RUN) begin
                        run_next = 1'b1;
                    end else if (i_rx_data == CMD_HALT) begin
                        run_next = 1'b0;
                    end else if (i_rx_data == CMD_STEP) begin
                        step_next = !run_reg;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            ST_LEN: begin
                if (i_rx_done) begin
                    timer_next = '0;
                    if (i_rx_data == '0) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        words_left_next = i_rx_data;
                        byte_cnt_next   = '0;
                        state_next      = ST_DATA;
                    end
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    timer_next = '0;
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            ST_DATA: begin
                if (i_rx_done) begin
                    timer_next = '0;
                    word_next  = word_shift;
                    if (byte_cnt_reg == BYTE_LAST) begin
                        byte_cnt_next = '0;
                        we_next       = 1'b1;
                        mem_addr_next = addr_cnt_reg;
                        addr_cnt_next = addr_cnt_reg + 1'b1;
                        if (words_left_reg == DATA_BITS'(1)) begin
                            done_next  = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            words_left_next = words_left_reg - 1'b1;
                        end
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                    end
                end else if (timeout_hit) begin
                    // Completed words stay written; the partial word is simply dropped.
                    err_next      = 1'b1;
                    timer_next    = '0;
                    byte_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_mem_we    = we_reg;
    assign o_mem_addr  = mem_addr_reg;
    assign o_mem_data  = word_reg;
    assign o_run       = run_reg;
    assign o_step      = step_reg;
    assign o_load_done = done_reg;
    assign o_err       = err_reg;

endmodule
